// File: rtl/flash_emu.sv
// ----------------------------------------------------------------------------
// flash_emu - SPI NOR flash emulator (single-bit SPI, mode 0), read-only.
//
// Oversamples the SPI pins on the fast system clock and answers 0x03 (read)
// and 0x0B (fast read) with an address-derived pattern: the byte returned for
// address A is A[7:0]. There is no memory array.
//
// Ports:
//   clk       in   system clock, at least 4x the SPI bit rate
//   rst_n     in   asynchronous active-low reset
//   spi_cs_n  in   chip select, active low, asynchronous to clk
//   spi_clk   in   SPI clock (mode 0, idles low), asynchronous to clk
//   spi_mosi  in   serial data from the master
//   spi_miso  out  serial data to the master (0 outside the data phase)
// ----------------------------------------------------------------------------
module flash_emu #(
    parameter int SYNC_STAGES = 2,
    parameter int DUMMY_FAST  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_cs_n,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic spi_miso
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DUMMY  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_FAST - 1);
    localparam logic       DUMMY_SKIP = (DUMMY_FAST == 0);

    // All three pins use the same depth so MOSI stays aligned with SCK.
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    logic w_sck, w_cs_n, w_mosi, w_rise, w_fall;
    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise = ~r_sck_prev & w_sck;
    assign w_fall = r_sck_prev & ~w_sck;

    logic [2:0]  r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_cmd;
    logic [23:0] r_addr;
    logic        r_fast;

    logic [7:0] w_cmd_next;
    logic [7:0] w_byte;
    assign w_cmd_next = {r_cmd[6:0], w_mosi};
    assign w_byte     = r_addr[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_cmd    <= '0;
            r_addr   <= '0;
            r_fast   <= 1'b0;
            spi_miso <= 1'b0;
        end else if (w_cs_n) begin
            // CS takes priority over any coincident SCK edge.
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_fast   <= 1'b0;
            spi_miso <= 1'b0;
        end else begin
            case (r_state)
                // IDLE with CS low behaves as the command phase, so the first
                // rise is captured even if it lands right after CS falls.
                ST_IDLE, ST_CMD: begin
                    spi_miso <= 1'b0;
                    if (w_rise) begin
                        r_cmd <= w_cmd_next;
                        r_cnt <= r_cnt + 8'd1;
                        r_state <= ST_CMD;
                        if (r_cnt == 8'd7) begin
                            r_cnt <= '0;
                            case (w_cmd_next)
                                8'h03:   begin r_state <= ST_ADDR; r_fast <= 1'b0; end
                                8'h0B:   begin r_state <= ST_ADDR; r_fast <= 1'b1; end
                                default: r_state <= ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    spi_miso <= 1'b0;
                    if (w_rise) begin
                        r_addr <= {r_addr[22:0], w_mosi};
                        r_cnt  <= r_cnt + 8'd1;
                        if (r_cnt == 8'd23) begin
                            r_cnt   <= '0;
                            r_state <= (r_fast && !DUMMY_SKIP) ? ST_DUMMY : ST_DATA;
                        end
                    end
                end
                ST_DUMMY: begin
                    spi_miso <= 1'b0;
                    if (w_rise) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == DUMMY_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // r_cnt[2:0] is the bit index within the byte; ~idx gives
                    // MSB-first ordering.
                    if (w_fall) begin
                        spi_miso <= w_byte[~r_cnt[2:0]];
                        if (r_cnt[2:0] == 3'd7) begin
                            r_cnt  <= '0;
                            r_addr <= r_addr + 24'd1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IGNORE;
                    spi_miso <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_emu.sv
module tb_flash_emu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_clk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] sb[$];
    logic [7:0] got[0:15];

    flash_emu #(.SYNC_STAGES(2), .DUMMY_FAST(8)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One SPI bit, half-period 4 clk. MISO is sampled right at the rising edge.
    task automatic sck_bit(input logic b, output logic m);
        spi_mosi = b;
        repeat (4) @(posedge clk);
        #2;
        m = spi_miso;
        spi_clk = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        spi_clk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            sck_bit(tx[i], m);
            rx[i] = m;
        end
    endtask

    task automatic cs_begin();
        @(posedge clk); #2;
        spi_cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic cs_end();
        repeat (4) @(posedge clk);
        #2;
        spi_cs_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        chk("miso_after_cs", {31'd0, spi_miso}, 32'd0);
    endtask

    task automatic xchk(input string tag, input logic [7:0] tx, output logic [7:0] rx);
        xfer(tx, rx);
        if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else chk(tag, {24'd0, rx}, {24'd0, sb.pop_front()});
    endtask

    // Full transaction; expected MISO bytes are queued before driving.
    task automatic rd(input logic [7:0] cmd, input logic [23:0] addr,
                      input int ndum, input int nbytes, input logic ign);
        logic [7:0] rx;
        logic [23:0] a;
        for (int i = 0; i < 4 + ndum; i++) sb.push_back(8'h00);
        for (int i = 0; i < nbytes; i++) begin
            a = addr + 24'(i);
            sb.push_back(ign ? 8'h00 : a[7:0]);
        end
        cs_begin();
        xchk("cmd", cmd, rx);
        xchk("addr2", addr[23:16], rx);
        xchk("addr1", addr[15:8], rx);
        xchk("addr0", addr[7:0], rx);
        for (int i = 0; i < ndum; i++) xchk("dummy", 8'hFF, rx);
        for (int i = 0; i < nbytes; i++) begin
            xchk("data", 8'($urandom), rx);
            got[i] = rx;
        end
        cs_end();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int nz;
        logic m;
        logic [7:0] rx;

        repeat (5) @(posedge clk);
        #2;
        chk("reset_miso", {31'd0, spi_miso}, 32'd0);
        rst_n = 1'b1;
        nz = 0;
        repeat (1000) begin
            @(negedge clk);
            if (spi_miso !== 1'b0) nz++;
        end
        chk("idle_1000", nz, 0);

        // Read at 0, 8 bytes; little-endian word assembly as a controller would.
        rd(8'h03, 24'h000000, 0, 8, 1'b0);
        chk("word0", {got[3], got[2], got[1], got[0]}, 32'h03020100);
        chk("word1", {got[7], got[6], got[5], got[4]}, 32'h07060504);

        // Wrap at the top of the 24-bit space.
        rd(8'h03, 24'hFFFFFE, 0, 4, 1'b0);
        chk("wrap", {got[0], got[1], got[2], got[3]}, 32'hFEFF0001);

        // Fast read: one dummy byte = 8 dummy SCK cycles, MISO 0 there.
        rd(8'h0B, 24'h000010, 1, 2, 1'b0);
        chk("fast", {16'd0, got[0], got[1]}, 32'h00001011);

        // Unknown commands keep MISO low for the whole frame.
        rd(8'hFF, 24'h123456, 0, 2, 1'b1);
        rd(8'hAB, 24'h000033, 0, 2, 1'b1);
        rd(8'h03, 24'h000020, 0, 1, 1'b0);
        chk("after_unknown", {24'd0, got[0]}, 32'h20);

        // Abort after 12 address bits.
        cs_begin();
        xfer(8'h03, rx);
        chk("abort_cmd", {24'd0, rx}, 32'd0);
        xfer(8'h00, rx);
        chk("abort_a2", {24'd0, rx}, 32'd0);
        nz = 0;
        for (int i = 0; i < 4; i++) begin
            sck_bit(1'b1, m);
            if (m !== 1'b0) nz++;
        end
        chk("abort_bits", nz, 0);
        cs_end();
        rd(8'h03, 24'h000040, 0, 2, 1'b0);
        chk("after_abort", {16'd0, got[0], got[1]}, 32'h00004041);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
